// File: rtl/ram_ctrl_pkg.sv
// Shared types and default widths for the RAM access controller.
package ram_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RSP,
        FILL
    } state_t;

endpackage

// File: rtl/ram_fill_seq.sv
// Fill address sequencer: walks every RAM word once and pulses done after the last one.
module ram_fill_seq
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  last,
    output logic [ADDR_WIDTH-1:0] addr
);

    logic [ADDR_WIDTH-1:0] cnt_reg;
    logic                  busy_reg;
    logic                  done_reg;

    assign busy = busy_reg;
    assign done = done_reg;
    assign addr = cnt_reg;
    assign last = busy_reg && (cnt_reg == {ADDR_WIDTH{1'b1}});

    // The counter parks at zero once the top word is written, so it never wraps inside a fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (busy_reg) begin
                if (last) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                    cnt_reg  <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else if (start) begin
                busy_reg <= 1'b1;
                cnt_reg  <= '0;
            end
        end
    end

endmodule

// File: rtl/ram_access_ctrl.sv
// Sole initiator of a single-port synchronous RAM: request/response port plus a whole-array fill engine.
module ram_access_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    input  logic                  fill_start,
    input  logic [DATA_WIDTH-1:0] fill_value,
    output logic                  fill_busy,
    output logic                  fill_done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    state_t                state_reg;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] fill_value_reg;
    logic                  rsp_valid_reg;
    logic [DATA_WIDTH-1:0] rsp_rdata_reg;
    logic                  fill_go;
    logic                  rd_accept;
    logic                  fill_last;
    logic [ADDR_WIDTH-1:0] fill_addr;

    ram_fill_seq #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_fill_seq (
        .clk  (clk),
        .rst  (rst),
        .start(fill_go),
        .busy (fill_busy),
        .done (fill_done),
        .last (fill_last),
        .addr (fill_addr)
    );

    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;

    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = addr_reg;
        ram_wdata  = req_wdata;
        fill_go    = 1'b0;
        rd_accept  = 1'b0;
        case (state_reg)
            IDLE: begin
                // Fill takes priority: a coincident request is neither accepted nor written.
                req_ready = ~fill_start;
                ram_addr  = req_addr;
                ram_we    = req_valid & req_we & ~fill_start;
                if (fill_start) begin
                    fill_go    = 1'b1;
                    state_next = FILL;
                end else if (req_valid && !req_we) begin
                    rd_accept  = 1'b1;
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: state_next = RSP;
            RSP: begin
                if (rsp_valid_reg && rsp_ready) begin
                    state_next = IDLE;
                end
            end
            FILL: begin
                ram_we    = 1'b1;
                ram_addr  = fill_addr;
                ram_wdata = fill_value_reg;
                if (fill_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (rst) begin
            ram_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            fill_value_reg <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_rdata_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (rd_accept) begin
                addr_reg <= req_addr;
            end
            if (fill_go) begin
                fill_value_reg <= fill_value;
            end
            // RAM q is valid during RD_WAIT because the address was registered on the accept edge.
            if (state_reg == RD_WAIT) begin
                rsp_valid_reg <= 1'b1;
                rsp_rdata_reg <= ram_q;
            end else if (state_reg == RSP && rsp_ready) begin
                rsp_valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench: behavioural RAM, transaction-level reference model, directed and random traffic.
module tb_ram_access_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          fill_start;
    logic [DW-1:0] fill_value;
    logic          fill_busy;
    logic          fill_done;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_q;

    ram_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .fill_start(fill_start),
        .fill_value(fill_value),
        .fill_busy (fill_busy),
        .fill_done (fill_done),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_q     (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: address registered on the edge, q read combinationally from the array.
    logic [DW-1:0] mem [DEPTH] = '{default: 8'h00};
    logic [AW-1:0] raddr_q = '0;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        raddr_q <= ram_addr;
    end
    assign ram_q = mem[raddr_q];

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    bit started = 0;
    bit rand_rsp = 0;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endfunction

    // Reference model: what the controller is doing, tracked as pending operations.
    logic [DW-1:0] model_mem [DEPTH] = '{default: 8'h00};
    bit            m_rd_wait   = 0;
    bit            m_rsp_valid = 0;
    bit            m_done      = 0;
    int            m_fill_idx  = -1;
    logic [DW-1:0] m_rsp_data  = '0;
    logic [DW-1:0] m_fill_val  = '0;
    logic [AW-1:0] m_rd_addr   = '0;
    bit            m_idle;
    bit            m_exp_we;

    always @(negedge clk) begin
        if (started) begin
            if (rst) begin
                chk("ram_we_in_reset", {31'b0, ram_we}, 0);
                m_rd_wait   = 0;
                m_rsp_valid = 0;
                m_done      = 0;
                m_fill_idx  = -1;
            end else begin
                m_idle = !m_rd_wait && !m_rsp_valid && (m_fill_idx < 0);
                chk("req_ready", {31'b0, req_ready}, {31'b0, m_idle && !fill_start});
                chk("fill_busy", {31'b0, fill_busy}, {31'b0, m_fill_idx >= 0});
                chk("fill_done", {31'b0, fill_done}, {31'b0, m_done});
                chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_rsp_valid});
                if (m_rsp_valid) chk("rsp_rdata", {24'b0, rsp_rdata}, {24'b0, m_rsp_data});
                if (m_fill_idx >= 0) begin
                    chk("fill_we", {31'b0, ram_we}, 1);
                    chk("fill_ram_addr", {27'b0, ram_addr}, m_fill_idx);
                    chk("fill_ram_wdata", {24'b0, ram_wdata}, {24'b0, m_fill_val});
                end else if (m_idle) begin
                    m_exp_we = req_valid && req_we && !fill_start;
                    chk("idle_we", {31'b0, ram_we}, {31'b0, m_exp_we});
                    if (m_exp_we) begin
                        chk("wr_ram_addr", {27'b0, ram_addr}, {27'b0, req_addr});
                        chk("wr_ram_wdata", {24'b0, ram_wdata}, {24'b0, req_wdata});
                    end
                end else begin
                    chk("read_we", {31'b0, ram_we}, 0);
                end

                m_done = 0;
                if (m_fill_idx >= 0) begin
                    model_mem[m_fill_idx] = m_fill_val;
                    if (m_fill_idx == DEPTH - 1) begin
                        m_fill_idx = -1;
                        m_done     = 1;
                    end else begin
                        m_fill_idx++;
                    end
                end else if (m_rd_wait) begin
                    m_rd_wait   = 0;
                    m_rsp_valid = 1;
                    m_rsp_data  = model_mem[m_rd_addr];
                end else if (m_rsp_valid) begin
                    if (rsp_ready) m_rsp_valid = 0;
                end else if (fill_start) begin
                    m_fill_idx = 0;
                    m_fill_val = fill_value;
                end else if (req_valid) begin
                    if (req_we) model_mem[req_addr] = req_wdata;
                    else begin
                        m_rd_wait = 1;
                        m_rd_addr = req_addr;
                    end
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rsp) rsp_ready = 1'($urandom_range(0, 1));
    end

    task automatic issue(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit acc = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            if (req_ready) acc = 1;
            @(posedge clk);
            #1;
        end
        chk("accept_timeout", {31'b0, acc}, 1);
        req_valid = 1'b0;
        if (we) $display("txn write addr=%0d data=%02h", a, d);
    endtask

    task automatic read_op(input logic [AW-1:0] a, output logic [DW-1:0] data, output int lat);
        bit got = 0;
        data = '0;
        lat  = 0;
        issue(1'b0, a, '0);
        for (int i = 1; i <= 50 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got  = 1;
                lat  = i;
                data = rsp_rdata;
            end
        end
        chk("rsp_timeout", {31'b0, got}, 1);
        for (int j = 0; j < 200; j++) begin
            if (rsp_ready) break;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        $display("txn read  addr=%0d data=%02h latency=%0d", a, data, lat);
    endtask

    task automatic count_fill(input int cycles, output int busy_cnt, output int done_cnt);
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (fill_busy) begin
                chk("fill_addr_seq", {27'b0, ram_addr}, busy_cnt);
                busy_cnt++;
            end
            if (fill_done) done_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] d;
    int            lat;
    int            t0;
    int            bc;
    int            dc;
    int            r;

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b1;
        fill_start = 1'b0;
        fill_value = '0;
        @(posedge clk);
        started = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 0);
        chk("reset_rsp_rdata", {24'b0, rsp_rdata}, 0);
        chk("reset_fill_busy", {31'b0, fill_busy}, 0);
        chk("reset_fill_done", {31'b0, fill_done}, 0);
        chk("reset_req_ready", {31'b0, req_ready}, 1);
        @(posedge clk);
        #1;

        // Single write then read with immediate consumer.
        issue(1'b1, 5'd3, 8'hA5);
        read_op(5'd3, d, lat);
        chk("a5_data", {24'b0, d}, 32'hA5);
        chk("a5_latency", lat, 2);

        // Back-to-back writes at one per cycle, then read-back.
        t0 = cycle;
        for (int a = 0; a < DEPTH; a++) issue(1'b1, AW'(a), DW'(a));
        chk("walk_cycles", cycle - t0, 32);
        for (int a = 0; a < DEPTH; a++) begin
            read_op(AW'(a), d, lat);
            chk("walk_rd", {24'b0, d}, a);
        end

        // Stalled consumer: response must hold stable.
        rsp_ready = 1'b0;
        issue(1'b0, 5'd7, '0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("hold_valid", {31'b0, rsp_valid}, 1);
            chk("hold_rdata", {24'b0, rsp_rdata}, 7);
            chk("hold_ready", {31'b0, req_ready}, 0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("handshake_ready", {31'b0, req_ready}, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post_hs_ready", {31'b0, req_ready}, 1);
        @(posedge clk);
        #1;
        $display("txn read  addr=7 held 5 cycles");

        // Fill with a coincident write request that must lose.
        fill_start = 1'b1;
        fill_value = 8'h3C;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 5'd5;
        req_wdata  = 8'h77;
        @(negedge clk);
        chk("fill_vs_req_ready", {31'b0, req_ready}, 0);
        @(posedge clk);
        #1;
        fill_start = 1'b0;
        req_valid  = 1'b0;
        count_fill(40, bc, dc);
        chk("fill_busy_cycles", bc, 32);
        chk("fill_done_pulses", dc, 1);
        $display("txn fill  value=3c busy=%0d done=%0d", bc, dc);
        read_op(5'd5, d, lat);
        chk("fill_rd5", {24'b0, d}, 32'h3C);
        read_op(5'd31, d, lat);
        chk("fill_rd31", {24'b0, d}, 32'h3C);

        // Reset during RD_WAIT drops the read.
        issue(1'b0, 5'd2, '0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rd_valid", {31'b0, rsp_valid}, 0);
        chk("rst_rd_ready", {31'b0, req_ready}, 1);
        @(posedge clk);
        #1;

        // Reset in fill cycle 10 abandons the fill.
        for (int a = 0; a < DEPTH; a++) issue(1'b1, AW'(a), DW'(a) ^ 8'h55);
        fill_start = 1'b1;
        fill_value = 8'h99;
        @(posedge clk);
        #1;
        fill_start = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        count_fill(40, bc, dc);
        chk("rst_fill_busy", bc, 0);
        chk("rst_fill_done", dc, 0);
        read_op(5'd9, d, lat);
        chk("rst_fill_rd9", {24'b0, d}, 32'h99);
        read_op(5'd10, d, lat);
        chk("rst_fill_rd10", {24'b0, d}, 32'h5F);
        read_op(5'd31, d, lat);
        chk("rst_fill_rd31", {24'b0, d}, 32'h4A);
        for (int a = 0; a < DEPTH; a++) read_op(AW'(a), d, lat);

        // Random traffic with a randomly stalling consumer.
        rand_rsp = 1;
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 45) begin
                issue(1'b1, AW'($urandom), DW'($urandom));
            end else if (r < 90) begin
                read_op(AW'($urandom), d, lat);
            end else if (r < 93) begin
                fill_start = 1'b1;
                fill_value = DW'($urandom);
                req_valid  = 1'($urandom_range(0, 1));
                req_we     = 1'($urandom_range(0, 1));
                req_addr   = AW'($urandom);
                req_wdata  = DW'($urandom);
                @(posedge clk);
                #1;
                req_valid = 1'b0;
                $display("txn fill  value=%02h", fill_value);
                for (int k = 1; k <= 33; k++) begin
                    fill_start = (k < 30) && ($urandom_range(0, 7) == 0);
                    fill_value = DW'($urandom);
                    @(posedge clk);
                    #1;
                end
                fill_start = 1'b0;
            end else begin
                repeat (int'($urandom_range(1, 3))) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        for (int a = 0; a < DEPTH; a++) read_op(AW'(a), d, lat);
        rand_rsp = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
